// File: rtl/clint_timer.sv
// clint_timer: shared 64-bit mtime with prescaler, per-hart mtimecmp/msip, valid/ready MMIO port
// Ports: clk, rst_n (sync, active-low); req_valid_i/req_ready_o/req_write_i/req_addr_i/req_wdata_i
//   request side; rsp_valid_o/rsp_ready_i/rsp_rdata_o/rsp_err_o response side;
//   mtip_o/msip_o registered per-channel timer and software interrupts.
module clint_timer #(
  parameter int XLEN = 32,
  parameter int NUM_CH = 2,
  parameter int PRESCALE_W = 8,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(32'h0200_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [NUM_CH-1:0] mtip_o,
  output logic [NUM_CH-1:0] msip_o
);
  localparam logic [5:0] NCH = 6'(NUM_CH);
  logic [XLEN-1:0] mtime_lo, mtime_hi, shadow_hi, off, rmux;
  logic [XLEN-1:0] cmp_lo [NUM_CH];
  logic [XLEN-1:0] cmp_hi [NUM_CH];
  logic [NUM_CH-1:0] msip_r;
  logic [PRESCALE_W-1:0] prescale, presc_cnt;
  logic [5:0] cmp_idx, msip_idx;
  logic en, shadow_vld, tick, acc, wr, rd, err;
  logic is_lo, is_hi, is_ctrl, is_pre, is_cmp, is_msip;
  assign off = req_addr_i - BASE_ADDR;
  assign cmp_idx = {1'b0, off[7:3]};
  assign msip_idx = off[7:2];
  assign is_lo = off == XLEN'('h0);
  assign is_hi = off == XLEN'('h4);
  assign is_ctrl = off == XLEN'('h8);
  assign is_pre = off == XLEN'('hC);
  assign is_cmp = off[XLEN-1:8] == (XLEN-8)'(1) && cmp_idx < NCH;
  assign is_msip = off[XLEN-1:8] == (XLEN-8)'(2) && msip_idx < NCH;
  assign err = off[1:0] != 2'b00 || !(is_lo || is_hi || is_ctrl || is_pre || is_cmp || is_msip);
  assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
  assign acc = req_valid_i & req_ready_o;
  assign wr = acc & req_write_i & ~err;
  assign rd = acc & ~req_write_i & ~err;
  assign tick = en && presc_cnt == prescale;
  always_comb begin
    rmux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (is_cmp && cmp_idx == 6'(i)) rmux = off[2] ? cmp_hi[i] : cmp_lo[i];
      if (is_msip && msip_idx == 6'(i)) rmux = {{(XLEN-1){1'b0}}, msip_r[i]};
    end
    if (is_lo) rmux = mtime_lo;
    if (is_hi) rmux = shadow_vld ? shadow_hi : mtime_hi;
    if (is_ctrl) rmux = {{(XLEN-1){1'b0}}, en};
    if (is_pre) rmux = XLEN'(prescale);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {mtime_hi, mtime_lo} <= '0;
      en <= 1'b1;
      prescale <= '0;
      presc_cnt <= '0;
      shadow_hi <= '0;
      shadow_vld <= 1'b0;
      msip_r <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
      mtip_o <= '0;
      msip_o <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_lo[i] <= '1;
        cmp_hi[i] <= '1;
      end
    end else begin
      // Bus writes to a counter half win over the tick; the carry between halves is dropped.
      if (wr && is_lo) mtime_lo <= req_wdata_i;
      else if (wr && is_hi) begin
        mtime_hi <= req_wdata_i;
        mtime_lo <= mtime_lo + XLEN'(tick);
      end else {mtime_hi, mtime_lo} <= {mtime_hi, mtime_lo} + (2*XLEN)'(tick);
      presc_cnt <= (wr && (is_ctrl || is_pre)) || tick ? '0 : en ? presc_cnt + 1'b1 : presc_cnt;
      if (wr && is_ctrl) en <= req_wdata_i[0];
      if (wr && is_pre) prescale <= req_wdata_i[PRESCALE_W-1:0];
      // Reading LO snapshots HI so a following HI read sees a consistent 64-bit value.
      if (rd && is_lo) begin
        shadow_hi <= mtime_hi;
        shadow_vld <= 1'b1;
      end else if ((rd && is_hi) || (wr && (is_lo || is_hi))) shadow_vld <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && is_cmp && cmp_idx == 6'(i) && off[2]) cmp_hi[i] <= req_wdata_i;
        if (wr && is_cmp && cmp_idx == 6'(i) && !off[2]) cmp_lo[i] <= req_wdata_i;
        if (wr && is_msip && msip_idx == 6'(i)) msip_r[i] <= req_wdata_i[0];
        mtip_o[i] <= {mtime_hi, mtime_lo} >= {cmp_hi[i], cmp_lo[i]};
        msip_o[i] <= msip_r[i];
      end
      if (acc) begin
        rsp_valid_o <= 1'b1;
        rsp_rdata_o <= rd ? rmux : '0;
        rsp_err_o <= err;
      end else if (rsp_ready_i) rsp_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed checks of counter, prescaler, atomic read, compare, msip, errors, backpressure
module tb_clint_timer;
  localparam logic [31:0] B = 32'h0200_0000;
  logic clk = 0, rst_n = 0, req_valid = 0, req_write = 0, rsp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0] mtip, msip;
  int checks = 0, failures = 0;
  clint_timer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mtip_o(mtip), .msip_o(msip)
  );
  always #5 clk = ~clk;
  task automatic bus(input logic w, input logic [31:0] o, input logic [31:0] d,
                     output logic [31:0] r, output logic e);
    req_valid = 1; req_write = w; req_addr = B + o; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0; r = rsp_rdata; e = rsp_err;
  endtask
  task automatic test_reset;
    logic [31:0] r; logic e;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
    checks++; if (mtip !== 2'b00 || msip !== 2'b00) begin failures++; $display("FAIL rst_irq got=%b/%b exp=00/00", mtip, msip); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    rst_n = 1;
    bus(0, 'h0, 0, r, e);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL mtime_first got=%h exp=0", r); end
    repeat (9) @(posedge clk); #1;
    bus(0, 'h0, 0, r, e);
    checks++; if (r !== 32'd10) begin failures++; $display("FAIL mtime_n got=%h exp=a", r); end
    checks++; if (mtip !== 2'b00) begin failures++; $display("FAIL mtip_idle got=%b exp=00", mtip); end
    bus(0, 'h8, 0, r, e);
    checks++; if (r !== 32'd1) begin failures++; $display("FAIL ctrl_rst got=%h exp=1", r); end
    bus(0, 'hC, 0, r, e);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL presc_rst got=%h exp=0", r); end
    bus(0, 'h100, 0, r, e);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cmp0_lo_rst got=%h exp=ffffffff", r); end
    bus(0, 'h10C, 0, r, e);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cmp1_hi_rst got=%h exp=ffffffff", r); end
  endtask
  task automatic test_prescale;
    logic [31:0] r; logic e;
    bus(1, 'h8, 0, r, e);
    bus(1, 'hC, 3, r, e);
    bus(1, 'h0, 0, r, e);
    bus(1, 'h4, 0, r, e);
    bus(1, 'h8, 1, r, e);
    bus(0, 'h0, 0, r, e);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL presc_k1 got=%h exp=0", r); end
    repeat (7) @(posedge clk); #1;
    bus(0, 'h0, 0, r, e);
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL presc_k9 got=%h exp=2", r); end
    bus(0, 'h0, 0, r, e);
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL presc_k10 got=%h exp=2", r); end
    repeat (2) @(posedge clk); #1;
    bus(0, 'h0, 0, r, e);
    checks++; if (r !== 32'd3) begin failures++; $display("FAIL presc_k13 got=%h exp=3", r); end
    bus(1, 'h8, 0, r, e);
    bus(0, 'h0, 0, r, e);
    checks++; if (r !== 32'd3) begin failures++; $display("FAIL freeze_a got=%h exp=3", r); end
    repeat (100) @(posedge clk); #1;
    bus(0, 'h0, 0, r, e);
    checks++; if (r !== 32'd3) begin failures++; $display("FAIL freeze_b got=%h exp=3", r); end
  endtask
  task automatic test_atomic;
    logic [31:0] r; logic e;
    bus(1, 'hC, 0, r, e);
    bus(1, 'h4, 0, r, e);
    bus(1, 'h0, 32'hFFFF_FFFE, r, e);
    bus(1, 'h8, 1, r, e);
    bus(0, 'h0, 0, r, e);
    checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL atomic_lo got=%h exp=fffffffe", r); end
    repeat (2) @(posedge clk); #1;
    bus(0, 'h4, 0, r, e);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL atomic_shadow_hi got=%h exp=0", r); end
    bus(0, 'h4, 0, r, e);
    checks++; if (r !== 32'd1) begin failures++; $display("FAIL atomic_live_hi got=%h exp=1", r); end
    bus(0, 'h0, 0, r, e);
    checks++; if (r !== 32'd3) begin failures++; $display("FAIL atomic_lo_after got=%h exp=3", r); end
  endtask
  task automatic test_mtip;
    logic [31:0] r; logic e;
    bus(1, 'h8, 0, r, e);
    bus(1, 'h10C, 0, r, e);
    bus(1, 'h108, 50, r, e);
    bus(1, 'h4, 0, r, e);
    bus(1, 'h0, 0, r, e);
    bus(1, 'h8, 1, r, e);
    for (int k = 1; k <= 55; k++) begin
      @(posedge clk); #1;
      if (k >= 45) begin
        checks++;
        if (mtip[1] !== (k >= 51)) begin failures++; $display("FAIL mtip1_k%0d got=%b exp=%b", k, mtip[1], k >= 51); end
      end
    end
    checks++; if (mtip[0] !== 1'b0) begin failures++; $display("FAIL mtip0_quiet got=%b exp=0", mtip[0]); end
    bus(1, 'h10C, 1, r, e);
    checks++; if (mtip[1] !== 1'b1) begin failures++; $display("FAIL mtip1_hold got=%b exp=1", mtip[1]); end
    @(posedge clk); #1;
    checks++; if (mtip[1] !== 1'b0) begin failures++; $display("FAIL mtip1_fall got=%b exp=0", mtip[1]); end
  endtask
  task automatic test_msip_err;
    logic [31:0] r; logic e;
    bus(1, 'h200, 32'hFFFF_FFFF, r, e);
    checks++; if (r !== 32'd0 || e !== 1'b0) begin failures++; $display("FAIL msip_wr_rsp got=%h/%b exp=0/0", r, e); end
    checks++; if (msip !== 2'b00) begin failures++; $display("FAIL msip_early got=%b exp=00", msip); end
    @(posedge clk); #1;
    checks++; if (msip !== 2'b01) begin failures++; $display("FAIL msip_out got=%b exp=01", msip); end
    bus(0, 'h200, 0, r, e);
    checks++; if (r !== 32'd1 || e !== 1'b0) begin failures++; $display("FAIL msip0_rd got=%h/%b exp=1/0", r, e); end
    bus(0, 'h204, 0, r, e);
    checks++; if (r !== 32'd0 || e !== 1'b0) begin failures++; $display("FAIL msip1_rd got=%h/%b exp=0/0", r, e); end
    bus(0, 'h208, 0, r, e);
    checks++; if (r !== 32'd0 || e !== 1'b1) begin failures++; $display("FAIL msip2_err got=%h/%b exp=0/1", r, e); end
    bus(0, 'h110, 0, r, e);
    checks++; if (r !== 32'd0 || e !== 1'b1) begin failures++; $display("FAIL cmp2_err got=%h/%b exp=0/1", r, e); end
    bus(0, 'h300, 0, r, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL unmapped_err got=%b exp=1", e); end
    bus(1, 'h002, 0, r, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b exp=1", e); end
    bus(1, 'h00A, 0, r, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL misalign_ctrl_err got=%b exp=1", e); end
    bus(0, 'h8, 0, r, e);
    checks++; if (r !== 32'd1) begin failures++; $display("FAIL misalign_no_write got=%h exp=1", r); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] r; logic e;
    bus(1, 'hC, 32'h1FF, r, e);
    checks++; if (rsp_valid !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL b2b_wr got=%b/%b exp=1/0", rsp_valid, e); end
    bus(0, 'hC, 0, r, e);
    checks++; if (rsp_valid !== 1'b1 || r !== 32'hFF) begin failures++; $display("FAIL b2b_presc got=%b/%h exp=1/ff", rsp_valid, r); end
    bus(0, 'h8, 0, r, e);
    checks++; if (rsp_valid !== 1'b1 || r !== 32'd1) begin failures++; $display("FAIL b2b_ctrl got=%b/%h exp=1/1", rsp_valid, r); end
  endtask
  task automatic test_backpressure_reset;
    logic [31:0] r; logic e;
    rsp_ready = 0;
    req_valid = 1; req_write = 0; req_addr = B + 'h8;
    @(posedge clk); #1;
    req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd1 || req_ready !== 1'b0) begin
        failures++; $display("FAIL hold_%0d got=%b/%h/%b exp=1/1/0", i, rsp_valid, rsp_rdata, req_ready);
      end
      @(posedge clk); #1;
    end
    rst_n = 0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || msip !== 2'b00 || mtip !== 2'b00) begin failures++; $display("FAIL midrst got=%b/%b/%b exp=0/00/00", rsp_valid, msip, mtip); end
    rst_n = 1; rsp_ready = 1;
    bus(0, 'h0, 0, r, e);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL midrst_mtime got=%h exp=0", r); end
    bus(0, 'hC, 0, r, e);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL midrst_presc got=%h exp=0", r); end
    bus(0, 'h200, 0, r, e);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL midrst_msip got=%h exp=0", r); end
    bus(0, 'h10C, 0, r, e);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midrst_cmp got=%h exp=ffffffff", r); end
  endtask
  initial begin
    repeat (3) @(posedge clk); #1;
    test_reset;
    test_prescale;
    test_atomic;
    test_mtip;
    test_msip_err;
    test_back_to_back;
    test_backpressure_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
